// File: rtl/vector_data_mem.sv
// Vector load/store of R lanes over a byte-wide single-port RAM. Store: Done at t+R+1, load: Done at t+R+2.
// Requests are accepted only in IDLE/DONE; while Busy they are dropped. OOB_CHECK_EN enables range checking.
module vector_data_mem #(
  parameter int I  = 32,
  parameter int N  = 8,
  parameter int R  = 6,
  parameter int AW = 10
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                MemReq,
  input  logic                MemWrite,
  input  logic [I-1:0]        Address,
  input  logic [R-1:0][N-1:0] WriteData,
  output logic [R-1:0][N-1:0] ReadData,
  output logic                Busy,
  output logic                Done,
  output logic                OOBErr
);

  localparam int DEPTH = 2 ** AW;
  localparam int CW    = (R > 1) ? $clog2(R) : 1;

  typedef enum logic [1:0] {IDLE, ACCESS, CAPTURE, DONE} state_t;

  state_t              state, nextState;
  logic [CW-1:0]       laneCnt;
  logic [AW-1:0]       baseAddr;
  logic [AW-1:0]       laneAddr;
  logic [R-1:0][N-1:0] wrData;
  logic                isWrite;
  logic                accept;
  logic                reqOob;
  logic                lastLane;
  logic                ramWe;
  logic [N-1:0]        ramRdData;
  logic [N-1:0]        mem [DEPTH];

  assign accept   = MemReq && ((state == IDLE) || (state == DONE));
  assign lastLane = (laneCnt == CW'(R - 1));
  assign laneAddr = baseAddr + AW'(laneCnt);
  // A write landing on the reset edge must not reach the RAM.
  assign ramWe    = (state == ACCESS) && isWrite && !reset;
  assign Busy     = (state == ACCESS) || (state == CAPTURE);
  assign Done     = (state == DONE);

`ifdef OOB_CHECK_EN
  localparam logic [I:0] DEPTH_X = (I + 1)'(DEPTH);
  localparam logic [I:0] SPAN    = (I + 1)'(R - 1);
  logic [I:0] lastAddr;
  logic       oobFlag;

  // One bit wider so the end-of-vector sum cannot wrap back into range.
  assign lastAddr = {1'b0, Address} + SPAN;
  assign reqOob   = ({1'b0, Address} >= DEPTH_X) || (lastAddr >= DEPTH_X);
  assign OOBErr   = Done && oobFlag;

  always_ff @(posedge clk) begin
    if (reset) begin
      oobFlag <= 1'b0;
    end else if (accept) begin
      oobFlag <= reqOob;
    end
  end
`else
  logic unusedAddrHi;

  assign unusedAddrHi = ^Address[I-1:AW];
  assign reqOob       = 1'b0;
  assign OOBErr       = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (ramWe) begin
      mem[laneAddr] <= wrData[laneCnt];
    end
    ramRdData <= mem[laneAddr];
  end

  always_comb begin
    nextState = state;
    case (state)
      IDLE, DONE: begin
        if (MemReq) begin
          nextState = reqOob ? DONE : ACCESS;
        end else begin
          nextState = IDLE;
        end
      end
      ACCESS: begin
        if (lastLane) begin
          nextState = isWrite ? DONE : CAPTURE;
        end
      end
      CAPTURE: nextState = DONE;
      default: nextState = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      laneCnt  <= '0;
      ReadData <= '0;
    end else begin
      state <= nextState;
      if (accept) begin
        baseAddr <= Address[AW-1:0];
        wrData   <= WriteData;
        isWrite  <= MemWrite;
        laneCnt  <= '0;
      end else if (state == ACCESS) begin
        laneCnt <= laneCnt + CW'(1);
      end
      // RAM read data lags the issued lane by one cycle.
      if ((state == ACCESS) && !isWrite && (laneCnt != '0)) begin
        ReadData[laneCnt - CW'(1)] <= ramRdData;
      end
      if (state == CAPTURE) begin
        ReadData[R-1] <= ramRdData;
      end
    end
  end

endmodule

// File: tb/tb_vector_data_mem.sv
// Directed bench for vector_data_mem: timing, data, wrap/range and reset-abort scenarios.
module tb_vector_data_mem;

  logic            clk;
  logic            reset;
  logic            MemReq;
  logic            MemWrite;
  logic [31:0]     Address;
  logic [5:0][7:0] WriteData;
  logic [5:0][7:0] ReadData;
  logic            Busy;
  logic            Done;
  logic            OOBErr;

  int tests = 0;
  int fails = 0;

  localparam logic [47:0] D1  = 48'h665544332211;
  localparam logic [47:0] D2  = 48'hF6F5F4F3F2F1;
  localparam logic [47:0] D3  = 48'hC5C4C3C2C1C0;
  localparam logic [47:0] D4  = 48'hD5D4D3D2D1D0;
  localparam logic [47:0] PRE = 48'hA5A4A3A2A1A0;
  localparam logic [47:0] NEW = 48'hB5B4B3B2B1B0;

  vector_data_mem dut (
    .clk      (clk),
    .reset    (reset),
    .MemReq   (MemReq),
    .MemWrite (MemWrite),
    .Address  (Address),
    .WriteData(WriteData),
    .ReadData (ReadData),
    .Busy     (Busy),
    .Done     (Done),
    .OOBErr   (OOBErr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Issue one request; return the cycle (relative to accept edge) where Done is seen.
  task automatic doOp(input logic wr, input logic [31:0] addr, input logic [47:0] data,
                      output int cyc, output bit busyOk);
    MemReq    = 1'b1;
    MemWrite  = wr;
    Address   = addr;
    WriteData = data;
    @(posedge clk); #1;
    MemReq = 1'b0;
    cyc    = 1;
    busyOk = 1'b1;
    while (Done !== 1'b1 && cyc < 40) begin
      if (Busy !== 1'b1) busyOk = 1'b0;
      @(posedge clk); #1;
      cyc++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; MemReq = 1'b0; MemWrite = 1'b0; Address = '0; WriteData = '0;
    repeat (3) @(posedge clk);
    #1;
    tests++; if (Busy !== 1'b0) begin fails++; $display("FAIL reset_busy got %b want 0", Busy); end
    tests++; if (Done !== 1'b0) begin fails++; $display("FAIL reset_done got %b want 0", Done); end
    tests++; if (OOBErr !== 1'b0) begin fails++; $display("FAIL reset_oob got %b want 0", OOBErr); end
    tests++; if (ReadData !== 48'h0) begin fails++; $display("FAIL reset_rdata got %h want 0", ReadData); end
    reset = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_store();
    int cyc; bit busyOk;
    doOp(1'b1, 32'h010, D1, cyc, busyOk);
    tests++; if (cyc != 7) begin fails++; $display("FAIL store_latency got %0d want 7", cyc); end
    tests++; if (!busyOk) begin fails++; $display("FAIL store_busy got gap want busy t+1..t+6"); end
    tests++; if (Busy !== 1'b0) begin fails++; $display("FAIL store_busy_done got %b want 0", Busy); end
    tests++; if (OOBErr !== 1'b0) begin fails++; $display("FAIL store_oob got %b want 0", OOBErr); end
    @(posedge clk); #1;
    tests++; if (Done !== 1'b0) begin fails++; $display("FAIL store_done_pulse got %b want 0", Done); end
  endtask

  task automatic test_load();
    int cyc; bit busyOk;
    doOp(1'b0, 32'h010, 48'h0, cyc, busyOk);
    tests++; if (cyc != 8) begin fails++; $display("FAIL load_latency got %0d want 8", cyc); end
    tests++; if (!busyOk) begin fails++; $display("FAIL load_busy got gap want busy t+1..t+7"); end
    tests++; if (Busy !== 1'b0) begin fails++; $display("FAIL load_busy_done got %b want 0", Busy); end
    tests++; if (ReadData !== D1) begin fails++; $display("FAIL load_data got %h want %h", ReadData, D1); end
  endtask

  task automatic test_wrap();
    int cyc; bit busyOk;
    logic [5:0][7:0] rd;
`ifdef OOB_CHECK_EN
    doOp(1'b1, 32'h3FA, D2, cyc, busyOk);
    tests++; if (cyc != 7) begin fails++; $display("FAIL inrange_store_latency got %0d want 7", cyc); end
    tests++; if (OOBErr !== 1'b0) begin fails++; $display("FAIL inrange_oob got %b want 0", OOBErr); end
    doOp(1'b1, 32'h3FE, D3, cyc, busyOk);
    tests++; if (cyc != 1) begin fails++; $display("FAIL oob_store_latency got %0d want 1", cyc); end
    tests++; if (OOBErr !== 1'b1) begin fails++; $display("FAIL oob_store_flag got %b want 1", OOBErr); end
    tests++; if (ReadData !== D1) begin fails++; $display("FAIL oob_store_rdata got %h want %h", ReadData, D1); end
    doOp(1'b0, 32'h3FA, 48'h0, cyc, busyOk);
    tests++; if (ReadData !== D2) begin fails++; $display("FAIL oob_ram_kept got %h want %h", ReadData, D2); end
    tests++; if (OOBErr !== 1'b0) begin fails++; $display("FAIL inrange_load_oob got %b want 0", OOBErr); end
    doOp(1'b0, 32'h400, 48'h0, cyc, busyOk);
    tests++; if (cyc != 1) begin fails++; $display("FAIL oob_load_latency got %0d want 1", cyc); end
    tests++; if (OOBErr !== 1'b1) begin fails++; $display("FAIL oob_load_flag got %b want 1", OOBErr); end
    tests++; if (ReadData !== D2) begin fails++; $display("FAIL oob_load_rdata got %h want %h", ReadData, D2); end
`else
    doOp(1'b1, 32'h3FE, D2, cyc, busyOk);
    tests++; if (cyc != 7) begin fails++; $display("FAIL wrap_store_latency got %0d want 7", cyc); end
    tests++; if (ReadData !== D1) begin fails++; $display("FAIL store_keeps_rdata got %h want %h", ReadData, D1); end
    doOp(1'b0, 32'h3FE, 48'h0, cyc, busyOk);
    tests++; if (ReadData !== D2) begin fails++; $display("FAIL wrap_load got %h want %h", ReadData, D2); end
    doOp(1'b0, 32'h000, 48'h0, cyc, busyOk);
    rd = ReadData;
    tests++; if (rd[3:0] !== 32'hF6F5F4F3) begin fails++; $display("FAIL wrap_low_lanes got %h want f6f5f4f3", rd[3:0]); end
    doOp(1'b0, 32'h410, 48'h0, cyc, busyOk);
    tests++; if (ReadData !== D1) begin fails++; $display("FAIL upper_addr_ignored got %h want %h", ReadData, D1); end
    tests++; if (OOBErr !== 1'b0) begin fails++; $display("FAIL oob_tied got %b want 0", OOBErr); end
`endif
  endtask

  task automatic test_busy_ignore();
    int nDone = 0, d1 = 0, d2 = 0, cyc;
    bit busyOk;
    MemReq = 1'b1; MemWrite = 1'b1; Address = 32'h030; WriteData = D3;
    @(posedge clk); #1;
    MemReq = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      if (Done === 1'b1) begin
        nDone++;
        if (nDone == 1) d1 = c;
        else if (nDone == 2) d2 = c;
      end
      case (c)
        3: begin MemReq = 1'b1; MemWrite = 1'b0; Address = 32'h100; end
        4: MemReq = 1'b0;
        5: begin MemReq = 1'b1; MemWrite = 1'b1; Address = 32'h038; WriteData = D4; end
        8: MemReq = 1'b0;
        default: ;
      endcase
      @(posedge clk); #1;
    end
    tests++; if (nDone != 2) begin fails++; $display("FAIL b2b_done_count got %0d want 2", nDone); end
    tests++; if (d1 != 7) begin fails++; $display("FAIL b2b_first_done got %0d want 7", d1); end
    tests++; if (d2 != 14) begin fails++; $display("FAIL b2b_second_done got %0d want 14", d2); end
    doOp(1'b0, 32'h030, 48'h0, cyc, busyOk);
    tests++; if (ReadData !== D3) begin fails++; $display("FAIL b2b_first_data got %h want %h", ReadData, D3); end
    doOp(1'b0, 32'h038, 48'h0, cyc, busyOk);
    tests++; if (ReadData !== D4) begin fails++; $display("FAIL b2b_second_data got %h want %h", ReadData, D4); end
  endtask

  task automatic test_reset_mid_store();
    int cyc; bit busyOk;
    doOp(1'b1, 32'h020, PRE, cyc, busyOk);
    MemReq = 1'b1; MemWrite = 1'b1; Address = 32'h020; WriteData = NEW;
    @(posedge clk); #1;
    MemReq = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    tests++; if (Busy !== 1'b0) begin fails++; $display("FAIL abort_store_busy got %b want 0", Busy); end
    tests++; if (Done !== 1'b0) begin fails++; $display("FAIL abort_store_done got %b want 0", Done); end
    tests++; if (ReadData !== 48'h0) begin fails++; $display("FAIL abort_store_rdata got %h want 0", ReadData); end
    doOp(1'b0, 32'h020, 48'h0, cyc, busyOk);
    tests++; if (ReadData !== 48'hA5A4A3B2B1B0) begin fails++; $display("FAIL abort_store_ram got %h want a5a4a3b2b1b0", ReadData); end
  endtask

  task automatic test_reset_capture();
    int nDone = 0;
    MemReq = 1'b1; MemWrite = 1'b0; Address = 32'h010;
    @(posedge clk); #1;
    MemReq = 1'b0;
    repeat (6) begin @(posedge clk); #1; end
    tests++; if (Busy !== 1'b1) begin fails++; $display("FAIL capture_busy got %b want 1", Busy); end
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    tests++; if (Done !== 1'b0) begin fails++; $display("FAIL abort_load_done got %b want 0", Done); end
    tests++; if (Busy !== 1'b0) begin fails++; $display("FAIL abort_load_busy got %b want 0", Busy); end
    tests++; if (ReadData !== 48'h0) begin fails++; $display("FAIL abort_load_rdata got %h want 0", ReadData); end
    repeat (3) begin
      @(posedge clk); #1;
      if (Done === 1'b1) nDone++;
    end
    tests++; if (nDone != 0) begin fails++; $display("FAIL abort_load_late_done got %0d want 0", nDone); end
  endtask

  initial begin
    test_reset();
    test_store();
    test_load();
    test_wrap();
    test_busy_ignore();
    test_reset_mid_store();
    test_reset_capture();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
